pin_bus_responder: RTL and testbench

- Target-side agent for the CPU external pin bus: rw, 16-bit addr, 16-bit data, lock, and the inta/intb interrupt lines.
- Decodes a word-addressed RAM window and one interrupt-control register.
- Answers each bus cycle by driving the shared lock line busy, then done. Returns read data on the data pins.
- Generates inta/intb levels for the CPU from software-written bits.
- Sits on the FPGA side of the pins, opposite the CPU. All tristate buffers live at the top level, driven by this block's *_oe outputs.

---
 rtl/pin_bus_responder.sv | 80 ++++++++
 tb/tb_pin_bus_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pin_bus_responder.sv
// pin_bus_responder: pin-bus target with a RAM window and an interrupt-control register.
module pin_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] INT_ADDR    = 16'hFFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic        o_data_oe,
  input  logic        i_lock,
  output logic        o_lock,
  output logic        o_lock_oe,
  output logic        o_inta,
  output logic        o_intb,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, TURN} state_t;
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);
  state_t state, state_n;
  logic lock_prev, rw_q, mem_q, start, hit_mem, hit_int, go;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0] data_q;
  logic [3:0] cnt;
  logic [15:0] ram [2**ADDR_BITS];
  assign hit_mem = i_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS];
  assign hit_int = i_addr == INT_ADDR;
  assign start = state == IDLE && i_lock && !lock_prev;
  assign go = start && (hit_mem || hit_int);
  assign o_busy = state != IDLE;
  assign o_lock_oe = state == BUSY || state == DONE;
  assign o_lock = state == DONE;
  assign o_data_oe = state == DONE && rw_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (go) state_n = WAIT_STATES > 0 ? BUSY : DONE;
      BUSY: if (cnt == 4'd0) state_n = DONE;
      DONE: state_n = TURN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lock_prev <= 1'b0;
      cnt <= 4'd0;
      rw_q <= 1'b0;
      mem_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      o_data <= '0;
      o_inta <= 1'b0;
      o_intb <= 1'b0;
    end else begin
      state <= state_n;
      // forcing lock_prev high in TURN stops a lingering lock level from retriggering
      if (state == IDLE) lock_prev <= i_lock;
      else if (state == TURN) lock_prev <= 1'b1;
      cnt <= go ? WS_M1 : cnt - 4'(state == BUSY);
      if (go) begin
        rw_q <= i_rw;
        mem_q <= hit_mem;
        addr_q <= i_addr[ADDR_BITS-1:0];
        data_q <= i_data;
      end
      if (go && i_rw) o_data <= hit_mem ? ram[i_addr[ADDR_BITS-1:0]] : {14'b0, o_intb, o_inta};
      if (state == DONE && !rw_q && !mem_q) begin
        o_inta <= data_q[0];
        o_intb <= data_q[1];
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && state == DONE && !rw_q && mem_q) ram[addr_q] <= data_q;
endmodule

// File: tb/tb_pin_bus_responder.sv
// tb_pin_bus_responder: directed bench; reads are scored by a monitor against a queue of expected data.
module tb_pin_bus_responder;
  logic clk = 0, rst = 1;
  logic rw[2], lock[2], doe[2], lk[2], lkoe[2], inta[2], intb[2], busy[2];
  logic [15:0] addr[2], wdat[2], dout[2];
  logic [15:0] q0[$], q1[$];
  logic [15:0] mexp;
  int errs = 0, checks = 0;
  int rd_cnt[2] = '{0, 0};
  int r0;

  always #5 clk = ~clk;

  pin_bus_responder #(.WAIT_STATES(2)) u0 (
    .clk(clk), .rst(rst), .i_rw(rw[0]), .i_addr(addr[0]), .i_data(wdat[0]),
    .o_data(dout[0]), .o_data_oe(doe[0]), .i_lock(lock[0]), .o_lock(lk[0]),
    .o_lock_oe(lkoe[0]), .o_inta(inta[0]), .o_intb(intb[0]), .o_busy(busy[0]));

  pin_bus_responder #(.WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .i_rw(rw[1]), .i_addr(addr[1]), .i_data(wdat[1]),
    .o_data(dout[1]), .o_data_oe(doe[1]), .i_lock(lock[1]), .o_lock(lk[1]),
    .o_lock_oe(lkoe[1]), .o_inta(inta[1]), .o_intb(intb[1]), .o_busy(busy[1]));

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic mon(input int d);
    rd_cnt[d]++;
    chk("lock_high_in_read_done", {14'b0, lkoe[d], lk[d]}, 16'h3);
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errs++;
      $display("FAIL unexpected_read dut%0d: got %h with no read outstanding", d, dout[d]);
    end else begin
      if (d == 0) mexp = q0.pop_front();
      else mexp = q1.pop_front();
      chk("read_data", dout[d], mexp);
    end
  endtask

  always @(negedge clk)
    for (int d = 0; d < 2; d++) if (doe[d]) mon(d);

  task automatic xfer(input int d, input logic r, input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] ex, input int ws);
    int n = 0;
    @(negedge clk);
    rw[d] = r; addr[d] = a; wdat[d] = wd; lock[d] = 1;
    if (r) begin
      if (d == 0) q0.push_back(ex);
      else q1.push_back(ex);
    end
    @(negedge clk);
    lock[d] = 0;
    while (n < 20 && lkoe[d] && !lk[d]) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 16'(n), 16'(ws));
    chk("done_state", {14'b0, lkoe[d], lk[d]}, 16'h3);
    @(negedge clk);
    chk("turn_state", {13'b0, lkoe[d], doe[d], busy[d]}, 16'h1);
    @(negedge clk);
    chk("idle_state", {15'b0, busy[d]}, 16'h0);
  endtask

  task automatic miss(input logic [15:0] a);
    @(negedge clk);
    rw[0] = 1; addr[0] = a; lock[0] = 1;
    @(negedge clk);
    lock[0] = 0;
    repeat (3) begin
      chk("miss_idle", {14'b0, busy[0], lkoe[0]}, 16'h0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rw[d] = 0; lock[d] = 0; addr[d] = 0; wdat[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", {10'b0, busy[d], lkoe[d], lk[d], doe[d], inta[d], intb[d]}, 16'h0);
      chk("reset_data", dout[d], 16'h0);
    end
    rst = 0;
    xfer(0, 0, 16'h8004, 16'hA5C3, 16'h0, 2);
    xfer(0, 1, 16'h8004, 16'h0, 16'hA5C3, 2);
    xfer(0, 0, 16'h83FF, 16'h1111, 16'h0, 2);
    xfer(0, 1, 16'h83FF, 16'h0, 16'h1111, 2);
    miss(16'h8400);
    miss(16'h7FFF);
    xfer(0, 0, 16'hFFF0, 16'h0001, 16'h0, 2);
    chk("int_after_0001", {14'b0, intb[0], inta[0]}, 16'h1);
    xfer(0, 0, 16'hFFF0, 16'hFFFE, 16'h0, 2);
    chk("int_after_fffe", {14'b0, intb[0], inta[0]}, 16'h2);
    xfer(0, 1, 16'hFFF0, 16'h0, 16'h0002, 2);
    xfer(0, 0, 16'hFFF0, 16'h0000, 16'h0, 2);
    chk("int_after_0000", {14'b0, intb[0], inta[0]}, 16'h0);
    xfer(0, 1, 16'h8004, 16'h0, 16'hA5C3, 2);
    xfer(1, 0, 16'h8123, 16'hBEEF, 16'h0, 0);
    xfer(1, 1, 16'h8123, 16'h0, 16'hBEEF, 0);
    xfer(1, 0, 16'h8124, 16'h5A5A, 16'h0, 0);
    xfer(1, 1, 16'h8124, 16'h0, 16'h5A5A, 0);
    r0 = rd_cnt[1];
    @(negedge clk);
    rw[1] = 1; addr[1] = 16'h8123; lock[1] = 1;
    q1.push_back(16'hBEEF);
    repeat (4) @(negedge clk);
    lock[1] = 0;
    repeat (3) @(negedge clk);
    chk("held_lock_one_txn", 16'(rd_cnt[1] - r0), 16'h1);
    chk("held_lock_idle", {15'b0, busy[1]}, 16'h0);
    xfer(0, 0, 16'h8010, 16'h0F0F, 16'h0, 2);
    xfer(0, 0, 16'hFFF0, 16'h0003, 16'h0, 2);
    chk("int_after_0003", {14'b0, intb[0], inta[0]}, 16'h3);
    @(negedge clk);
    rw[0] = 0; addr[0] = 16'h8010; wdat[0] = 16'h1234; lock[0] = 1;
    @(negedge clk);
    lock[0] = 0;
    chk("in_busy_before_reset", {14'b0, busy[0], lkoe[0]}, 16'h3);
    rst = 1;
    @(negedge clk);
    chk("reset_mid_busy", {11'b0, busy[0], lkoe[0], doe[0], inta[0], intb[0]}, 16'h0);
    rst = 0;
    xfer(0, 1, 16'h8010, 16'h0, 16'h0F0F, 2);
    r0 = rd_cnt[0] + rd_cnt[1];
    @(negedge clk);
    rw[0] = 1; addr[0] = 16'h8004; lock[0] = 1;
    rw[1] = 1; addr[1] = 16'h8123; lock[1] = 1;
    rst = 1;
    @(negedge clk);
    lock[0] = 0; lock[1] = 0; rst = 0;
    repeat (3) begin
      for (int d = 0; d < 2; d++)
        chk("rst_beats_start", {13'b0, busy[d], lkoe[d], doe[d]}, 16'h0);
      @(negedge clk);
    end
    chk("rst_start_no_read", 16'(rd_cnt[0] + rd_cnt[1] - r0), 16'h0);
    chk("all_reads_seen", 16'(q0.size() + q1.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
